reflet_boot_sequencer: RTL

Parametrised reset and boot sequencer for Reflet microcontrollers. It generalises the fixed power-on reset gating of the 8-bit controller and makes the instruction memory loadable at boot. After reset it holds the CPU in reset for a configurable time, then either releases it directly or loads a program from the UART byte stream into instruction RAM, checks it, and releases the CPU. It sits between the UART receiver, the instruction RAM write port and the CPU reset input.

---
 rtl/reflet_boot_pkg.sv | 20 ++
 rtl/reflet_boot_timeout.sv | 30 +++
 rtl/reflet_boot_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reflet_boot_pkg.sv
// Shared types and helpers for the Reflet reset/boot sequencer.
package reflet_boot_pkg;

  typedef enum logic [2:0] {
    ST_POR,
    ST_WAIT_MAGIC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_RUN
  } boot_state_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  function automatic int unsigned byte_lanes(input int unsigned wordsize);
    return wordsize / 8;
  endfunction

endpackage

// File: rtl/reflet_boot_timeout.sv
// Inter-byte idle timer: reloads on kick, counts down while enabled,
// flags expiry on the timeout_cycles-th idle cycle after the last kick.
module reflet_boot_timeout #(
  parameter int unsigned timeout_cycles = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned tw = $clog2(timeout_cycles + 1);
  localparam logic [tw-1:0] load_val = tw'(timeout_cycles - 1);

  logic [tw-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (kick) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - tw'(1);
    end
  end

  assign expired = enable && !kick && (count == '0);

endmodule

// File: rtl/reflet_boot_sequencer.sv
// Holds the CPU in reset after power-up, then optionally loads instruction
// RAM from the UART byte stream (magic, length, words, checksum).
//
// state         | meaning
// --------------+--------------------------------------------------
// ST_POR        | counting the CPU reset hold time
// ST_WAIT_MAGIC | discarding bytes until the header byte arrives
// ST_LEN_LO     | expecting word count, low byte
// ST_LEN_HI     | expecting word count, high byte; range check
// ST_DATA       | assembling little-endian words, writing RAM
// ST_CHECK      | expecting the modulo-256 sum of all data bytes
// ST_RUN        | CPU released; terminal until reset
module reflet_boot_sequencer
  import reflet_boot_pkg::*;
#(
  parameter int unsigned wordsize       = 8,
  parameter int unsigned addr_size      = 7,
  parameter int unsigned por_cycles     = 16,
  parameter logic [7:0]  magic          = DEFAULT_MAGIC,
  parameter int unsigned timeout_cycles = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 boot_skip,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [addr_size-1:0] mem_addr,
  output logic [wordsize-1:0]  mem_data,
  output logic                 mem_write_en,
  output logic                 cpu_reset,
  output logic                 boot_busy,
  output logic                 boot_error
);

  localparam int unsigned lanes  = byte_lanes(wordsize);
  localparam int unsigned lane_w = (lanes > 1) ? $clog2(lanes) : 1;
  localparam int unsigned por_w  = (por_cycles > 1) ? $clog2(por_cycles) : 1;
  localparam int unsigned len_w  = addr_size + 1;
  localparam int unsigned depth  = 1 << addr_size;
  localparam logic [por_w-1:0]  por_last  = por_w'(por_cycles - 1);
  localparam logic [lane_w-1:0] lane_last = lane_w'(lanes - 1);

  boot_state_t         state, state_nxt;
  logic [por_w-1:0]    por_cnt, por_cnt_nxt;
  logic [7:0]          len_lo, len_lo_nxt;
  logic [len_w-1:0]    len, len_nxt;
  logic [len_w-1:0]    word_cnt, word_cnt_nxt;
  logic [lane_w-1:0]   lane, lane_nxt;
  logic [wordsize-1:0] word_buf, word_buf_nxt, word_asm;
  logic [7:0]          checksum, checksum_nxt;
  logic [addr_size-1:0] mem_addr_nxt;
  logic [wordsize-1:0] mem_data_nxt;
  logic                mem_write_en_nxt;
  logic                boot_error_nxt;
  logic [31:0]         len_rx;
  logic                fail;
  logic                timer_en, timer_expired;

  assign timer_en = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                    (state == ST_DATA)   || (state == ST_CHECK);

  reflet_boot_timeout #(.timeout_cycles(timeout_cycles)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en),
    .kick   (rx_valid),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_POR;
      por_cnt      <= '0;
      len_lo       <= '0;
      len          <= '0;
      word_cnt     <= '0;
      lane         <= '0;
      word_buf     <= '0;
      checksum     <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      boot_error   <= 1'b0;
    end else begin
      state        <= state_nxt;
      por_cnt      <= por_cnt_nxt;
      len_lo       <= len_lo_nxt;
      len          <= len_nxt;
      word_cnt     <= word_cnt_nxt;
      lane         <= lane_nxt;
      word_buf     <= word_buf_nxt;
      checksum     <= checksum_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_data     <= mem_data_nxt;
      mem_write_en <= mem_write_en_nxt;
      boot_error   <= boot_error_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    por_cnt_nxt      = por_cnt;
    len_lo_nxt       = len_lo;
    len_nxt          = len;
    word_cnt_nxt     = word_cnt;
    lane_nxt         = lane;
    word_buf_nxt     = word_buf;
    checksum_nxt     = checksum;
    // address advances in the cycle after each write strobe
    mem_addr_nxt     = mem_write_en ? (mem_addr + addr_size'(1)) : mem_addr;
    mem_data_nxt     = mem_data;
    mem_write_en_nxt = 1'b0;
    boot_error_nxt   = boot_error;
    fail             = 1'b0;
    word_asm         = word_buf;
    word_asm[{lane, 3'b000} +: 8] = rx_data;
    len_rx           = {16'h0000, rx_data, len_lo};

    case (state)
      ST_POR: begin
        if (por_cnt == por_last) begin
          state_nxt = boot_skip ? ST_RUN : ST_WAIT_MAGIC;
        end else begin
          por_cnt_nxt = por_cnt + por_w'(1);
        end
      end
      ST_WAIT_MAGIC: begin
        if (rx_valid && (rx_data == magic)) begin
          state_nxt    = ST_LEN_LO;
          mem_addr_nxt = '0;
          word_cnt_nxt = '0;
          lane_nxt     = '0;
          checksum_nxt = '0;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_lo_nxt = rx_data;
          state_nxt  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          if ((len_rx == '0) || (len_rx > depth)) begin
            fail = 1'b1;
          end else begin
            len_nxt   = len_rx[addr_size:0];
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          checksum_nxt = checksum + rx_data;
          word_buf_nxt = word_asm;
          if (lane == lane_last) begin
            lane_nxt         = '0;
            mem_data_nxt     = word_asm;
            mem_write_en_nxt = 1'b1;
            word_cnt_nxt     = word_cnt + len_w'(1);
            if (word_cnt_nxt == len) state_nxt = ST_CHECK;
          end else begin
            lane_nxt = lane + lane_w'(1);
          end
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == checksum) begin
            state_nxt      = ST_RUN;
            boot_error_nxt = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end
      end
      ST_RUN: ;
      default: state_nxt = ST_POR;
    endcase

    if (timer_expired) fail = 1'b1;

    if (fail) begin
      state_nxt      = ST_WAIT_MAGIC;
      boot_error_nxt = 1'b1;
      checksum_nxt   = '0;
      word_cnt_nxt   = '0;
      lane_nxt       = '0;
    end
  end

  assign cpu_reset = (state == ST_RUN);
  assign boot_busy = (state != ST_RUN);

endmodule
